// File: rtl/load_store_unit_pkg.sv
// Shared encodings, FSM states and store-lane helpers for the M-stage load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Misaligned halfword/word or an unsupported size encoding.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] a);
    logic f;
    case (f3[1:0])
      SZ_H:    f = a[0];
      SZ_W:    f = (a != 2'b00);
      SZ_BAD:  f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3[1:0])
      SZ_B:    s = 4'(STRB_B << a);
      SZ_H:    s = 4'(STRB_H << a);
      default: s = STRB_W;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension of a returned memory word.
module lsu_load_ext
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      F3_B:    data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_c = {24'b0, shifted[7:0]};
      F3_HU:   data_c = {16'b0, shifted[15:0]};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store responder: issues one valid/ready bus access per op and stalls the pipe until done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic              loadM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic              StallLSU,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              LsuFaultM,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  lsu_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              stall_c;
  logic [XLEN-1:0]   ext_data_c;

  lsu_load_ext u_load_ext (
    .rdata    (mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (req_q.funct3),
    .data_c   (ext_data_c)
  );

  // Next-state, request capture and result generation; results are non-zero only on entry to DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    fault_d = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemWriteM || loadM) begin
          stall_c      = 1'b1;
          addr_d       = ALUResultM;
          req_d.we     = MemWriteM;
          req_d.funct3 = funct3M;
          req_d.wstrb  = MemWriteM ? store_strb(funct3M, ALUResultM[1:0]) : STRB_NONE;
          req_d.wdata  = store_data(funct3M, WriteDataM);
          cnt_d        = '0;
          if (access_fault(funct3M, ALUResultM[1:0])) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (mem_req_ready) begin
          state_d = req_q.we ? ST_DONE : ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rdata_d = ext_data_c;
          state_d = ST_DONE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Reset masks the handshake outputs in the same cycle so no request leaks out.
  assign StallLSU      = stall_c & ~reset;
  assign mem_req_valid = (state_q == ST_REQ) & ~reset;
  assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_we        = req_q.we;
  assign mem_wstrb     = req_q.wstrb;
  assign mem_wdata     = req_q.wdata;
  assign ReadDataM     = rdata_q;
  assign LsuFaultM     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: per-op scoreboard plus a cycle-level bus responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, loadM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallLSU;
  logic [31:0] ReadDataM;
  logic        LsuFaultM;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          stall;
    logic        req;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWriteM     (MemWriteM),
    .loadM         (loadM),
    .funct3M       (funct3M),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .StallLSU      (StallLSU),
    .ReadDataM     (ReadDataM),
    .LsuFaultM     (LsuFaultM),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".stall"}, 32'(StallLSU), 32'd0);
    check({tag, ".rdata"}, ReadDataM, 32'd0);
    check({tag, ".fault"}, 32'(LsuFaultM), 32'd0);
    check({tag, ".valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, ".addr"}, mem_addr, 32'd0);
    check({tag, ".we"}, 32'(mem_we), 32'd0);
    check({tag, ".wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, ".wdata"}, mem_wdata, 32'd0);
  endtask

  // Called at a falling edge; returns at the DONE cycle so a following op can be issued back-to-back.
  task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ready_dly, input int rsp_dly, input logic [31:0] rd,
                        input logic [31:0] exp_data, input logic exp_fault, input int exp_stall,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    exp_t e;
    exp_t got;
    int   stall_n = 0;
    int   wait_n  = 0;
    int   req_n   = 0;
    logic accepted = 1'b0;
    logic req_seen = 1'b0;
    logic leak     = 1'b0;
    logic done     = 1'b0;
    e.data  = exp_data;
    e.fault = exp_fault;
    e.stall = exp_stall;
    e.req   = (exp_stall > 1);
    sb.push_back(e);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      if (cyc == 0) begin
        MemWriteM  = st;
        loadM      = ~st;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = d;
      end
      #1;
      if (StallLSU) begin
        stall_n++;
        if (ReadDataM !== 32'd0 || LsuFaultM !== 1'b0) leak = 1'b1;
      end
      if (mem_req_valid) begin
        req_seen = 1'b1;
        check({name, ".addr"}, mem_addr, {a[31:2], 2'b00});
        check({name, ".we"}, 32'(mem_we), 32'(st));
        check({name, ".wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
        if (st) check({name, ".wdata"}, mem_wdata, exp_wdata);
        if (req_n >= ready_dly) begin
          mem_req_ready = 1'b1;
          accepted      = 1'b1;
        end
        req_n++;
      end else if (accepted && !st) begin
        wait_n++;
        if (wait_n == rsp_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
        end
      end
      if (!StallLSU && stall_n > 0) begin
        done      = 1'b1;
        MemWriteM = 1'b0;
        loadM     = 1'b0;
        if (sb.size() == 0) begin
          check({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          check({name, ".rdata"}, ReadDataM, got.data);
          check({name, ".fault"}, 32'(LsuFaultM), 32'(got.fault));
          check({name, ".stall"}, 32'(stall_n), 32'(got.stall));
          check({name, ".req"}, 32'(req_seen), 32'(got.req));
          check({name, ".quiet"}, 32'(leak), 32'd0);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemWriteM = 1'b0; loadM = 1'b0; funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);

    run_op("sb",      1'b1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 32'h0,
           32'h0, 1'b0, 2, 4'b1000, 32'hA5A5A5A5);
    run_op("lh",      1'b0, 3'b001, 32'h2002, 32'h0, 0, 3, 32'h80011234,
           32'hFFFF8001, 1'b0, 5, 4'b0000, 32'h0);
    run_op("lw_mis",  1'b0, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0,
           32'h0, 1'b1, 1, 4'b0000, 32'h0);
    run_op("lbu",     1'b0, 3'b100, 32'h4001, 32'h0, 0, 1, 32'h0000FF00,
           32'h000000FF, 1'b0, 3, 4'b0000, 32'h0);
    run_op("lb",      1'b0, 3'b000, 32'h4001, 32'h0, 0, 1, 32'h0000FF00,
           32'hFFFFFFFF, 1'b0, 3, 4'b0000, 32'h0);
    run_op("sh",      1'b1, 3'b001, 32'h4002, 32'h0000BEEF, 0, 0, 32'h0,
           32'h0, 1'b0, 2, 4'b1100, 32'hBEEFBEEF);
    run_op("sh_hold", 1'b1, 3'b001, 32'h4000, 32'h77775A5A, 2, 0, 32'h0,
           32'h0, 1'b0, 4, 4'b0011, 32'h5A5A5A5A);
    run_op("sb_lane1", 1'b1, 3'b000, 32'h9001, 32'hFFFFFF3C, 0, 0, 32'h0,
           32'h0, 1'b0, 2, 4'b0010, 32'h3C3C3C3C);
    run_op("lhu",     1'b0, 3'b101, 32'h8002, 32'h0, 0, 2, 32'hABCD1234,
           32'h0000ABCD, 1'b0, 4, 4'b0000, 32'h0);
    run_op("lh_pos",  1'b0, 3'b001, 32'h8000, 32'h0, 1, 1, 32'hABCD7FFF,
           32'h00007FFF, 1'b0, 4, 4'b0000, 32'h0);
    run_op("sh_mis",  1'b1, 3'b001, 32'h8001, 32'h00001111, 0, 0, 32'h0,
           32'h0, 1'b1, 1, 4'b0000, 32'h0);
    run_op("illegal", 1'b0, 3'b011, 32'h8000, 32'h0, 0, 0, 32'h0,
           32'h0, 1'b1, 1, 4'b0000, 32'h0);
    run_op("lw_to",   1'b0, 3'b010, 32'h5000, 32'h0, 0, 0, 32'h0,
           32'h0, 1'b1, 10, 4'b0000, 32'h0);
    @(negedge clk);
    #1;
    check("post_to.stall", 32'(StallLSU), 32'd0);
    check("post_to.valid", 32'(mem_req_valid), 32'd0);
    check("post_to.fault", 32'(LsuFaultM), 32'd0);

    // Reset while waiting for a load response, then a stale response arrives.
    @(negedge clk);
    loadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h6000;
    #1;
    check("rst.stall_idle", 32'(StallLSU), 32'd1);
    @(negedge clk);
    #1;
    check("rst.req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("rst.wait_stall", 32'(StallLSU), 32'd1);
    check("rst.wait_novalid", 32'(mem_req_valid), 32'd0);
    reset = 1'b1; loadM = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_idle_outputs("rst.after");
    @(negedge clk);
    #1;
    check("rst.stale_rdata", ReadDataM, 32'd0);
    check("rst.stale_fault", 32'(LsuFaultM), 32'd0);
    check("rst.stale_stall", 32'(StallLSU), 32'd0);
    @(negedge clk);

    run_op("sw_b2b",  1'b1, 3'b010, 32'h7000, 32'h12345678, 0, 0, 32'h0,
           32'h0, 1'b0, 2, 4'b1111, 32'h12345678);
    run_op("lw_b2b",  1'b0, 3'b010, 32'h7004, 32'h0, 0, 1, 32'hCAFEF00D,
           32'hCAFEF00D, 1'b0, 3, 4'b0000, 32'h0);
    @(negedge clk);
    #1;
    check("end.stall", 32'(StallLSU), 32'd0);
    check("end.sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
